// File: rtl/rgbmixer_n.sv
`default_nettype none
// ============================================================================
// rgbmixer_n : N-channel quadrature encoder to first-order PDM LED mixer.
//   Optional illegal-transition flagging enabled by macro RGBMIXER_ERROR_EN.
//   Revision : 1.0
// ============================================================================
module rgbmixer_n #(
  parameter int WIDTH           = 8,
  parameter int CHANNELS        = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SATURATE        = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       knoba,
  input  logic [CHANNELS-1:0]       knobb,
  output logic [CHANNELS-1:0]       led,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       error
);

  localparam int                 c_cnt_w     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0]   c_level_max = '1;
  localparam logic [WIDTH-1:0]   c_one       = WIDTH'(1);

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      // Line pairs are kept as {a,b}; bit 1 is A, bit 0 is B.
      logic [1:0]         sync1_q, sync1_d;
      logic [1:0]         sync2_q, sync2_d;
      logic [1:0]         deb_q, deb_d;
      logic [1:0]         prev_q, prev_d;
      logic [c_cnt_w-1:0] cnt_q [2];
      logic [c_cnt_w-1:0] cnt_d [2];
      logic [WIDTH-1:0]   level_q, level_d;
      logic [WIDTH-1:0]   acc_q, acc_d;
      logic               led_q, led_d;
      logic               w_fwd, w_rev;
      logic [WIDTH:0]     w_sum;

      always_comb begin
        sync1_d = {knoba[c], knobb[c]};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int i = 0; i < 2; i++) begin
          cnt_d[i] = '0;
          if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == c_cnt_last) deb_d[i] = sync2_q[i];
            else                        cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end

      // Forward Gray order is 00 -> 10 -> 11 -> 01 -> 00; anything else holds.
      always_comb begin
        w_fwd = 1'b0;
        w_rev = 1'b0;
        case ({prev_q, deb_q})
          4'b0010, 4'b1011, 4'b1101, 4'b0100: w_fwd = 1'b1;
          4'b0001, 4'b0111, 4'b1110, 4'b1000: w_rev = 1'b1;
          default: ;
        endcase
      end

      always_comb begin
        prev_d  = deb_q;
        level_d = level_q;
        if (w_fwd) begin
          if (SATURATE == 0 || level_q != c_level_max) level_d = level_q + c_one;
        end else if (w_rev) begin
          if (SATURATE == 0 || level_q != '0) level_d = level_q - c_one;
        end
        w_sum = {1'b0, acc_q} + {1'b0, level_q};
        acc_d = w_sum[WIDTH-1:0];
        led_d = w_sum[WIDTH];
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          sync1_q  <= '0;
          sync2_q  <= '0;
          deb_q    <= '0;
          cnt_q[0] <= '0;
          cnt_q[1] <= '0;
          prev_q   <= '0;
          level_q  <= '0;
          acc_q    <= '0;
          led_q    <= 1'b0;
        end else begin
          sync1_q  <= sync1_d;
          sync2_q  <= sync2_d;
          deb_q    <= deb_d;
          cnt_q[0] <= cnt_d[0];
          cnt_q[1] <= cnt_d[1];
          prev_q   <= prev_d;
          level_q  <= level_d;
          acc_q    <= acc_d;
          led_q    <= led_d;
        end
      end

`ifdef RGBMIXER_ERROR_EN
      logic err_q, err_d;

      always_comb begin
        err_d = err_q | (&(prev_q ^ deb_q));
      end

      always_ff @(posedge clk) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
      end

      assign error[c] = err_q;
`else
      assign error[c] = 1'b0;
`endif

      assign led[c]                   = led_q;
      assign value[c*WIDTH +: WIDTH]  = level_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rgbmixer_n.sv
`default_nettype none
// tb_rgbmixer_n : scoreboard bench with a saturating and a wrapping instance
// (WIDTH=4, DEBOUNCE_CYCLES=4, CHANNELS=3) sharing the same input stimulus.
module tb_rgbmixer_n;
  localparam int W  = 4;
  localparam int N  = 3;
  localparam int DB = 4;
`ifdef RGBMIXER_ERROR_EN
  localparam bit c_err_en = 1'b1;
`else
  localparam bit c_err_en = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   knoba = '0;
  logic [N-1:0]   knobb = '0;
  logic [N-1:0]   led_s, led_w, err_s, err_w;
  logic [N*W-1:0] val_s, val_w;

  always #5 clk = ~clk;

  rgbmixer_n #(.WIDTH(W), .CHANNELS(N), .DEBOUNCE_CYCLES(DB), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .knoba(knoba), .knobb(knobb),
    .led(led_s), .value(val_s), .error(err_s));

  rgbmixer_n #(.WIDTH(W), .CHANNELS(N), .DEBOUNCE_CYCLES(DB), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .knoba(knoba), .knobb(knobb),
    .led(led_w), .value(val_w), .error(err_w));

  typedef struct packed {
    logic [N*W-1:0] sat;
    logic [N*W-1:0] wrap;
    logic [N-1:0]   err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         lvl_s[N];
  int         lvl_w[N];
  logic [N-1:0] err_m;
  logic [1:0] pair[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] pair_at(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic exp_t snap();
    exp_t e;
    for (int c = 0; c < N; c++) begin
      e.sat[c*W +: W]  = W'(lvl_s[c]);
      e.wrap[c*W +: W] = W'(lvl_w[c]);
    end
    e.err = err_m;
    return e;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      lvl_s[c] = 0;
      lvl_w[c] = 0;
      pair[c]  = 2'b00;
    end
    err_m = '0;
  endtask

  task automatic model_apply(input int c, input logic [1:0] ab);
    int d;
    d = (gray_pos(ab) - gray_pos(pair[c]) + 4) % 4;
    if (d == 1) begin
      lvl_s[c] = (lvl_s[c] == 15) ? 15 : lvl_s[c] + 1;
      lvl_w[c] = (lvl_w[c] + 1) % 16;
    end else if (d == 3) begin
      lvl_s[c] = (lvl_s[c] == 0) ? 0 : lvl_s[c] - 1;
      lvl_w[c] = (lvl_w[c] + 15) % 16;
    end else if (d == 2) begin
      if (c_err_en) err_m[c] = 1'b1;
    end
    pair[c] = ab;
  endtask

  task automatic drive(input int c, input logic [1:0] ab);
    @(negedge clk);
    knoba[c] = ab[1];
    knobb[c] = ab[0];
    model_apply(c, ab);
    sb_q.push_back(snap());
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_val_sat"},  32'(val_s), 32'(e.sat));
      check({tag, "_val_wrap"}, 32'(val_w), 32'(e.wrap));
      check({tag, "_err_sat"},  32'(err_s), 32'(e.err));
      check({tag, "_err_wrap"}, 32'(err_w), 32'(e.err));
    end
  endtask

  task automatic settle(input int edges);
    repeat (edges) @(posedge clk);
    #1;
  endtask

  task automatic step(input int c, input logic [1:0] ab, input string tag);
    drive(c, ab);
    settle(10);
    compare(tag);
  endtask

  task automatic fwd(input int c, input string tag);
    step(c, pair_at(gray_pos(pair[c]) + 1), tag);
  endtask

  task automatic rev(input int c, input string tag);
    step(c, pair_at(gray_pos(pair[c]) + 3), tag);
  endtask

  task automatic pdm_check(input string tag, input int c);
    int os;
    int ow;
    os = 0;
    ow = 0;
    settle(4);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      os += int'(led_s[c]);
      ow += int'(led_w[c]);
    end
    check({tag, "_ones_sat"},  32'(os), 32'(lvl_s[c]));
    check({tag, "_ones_wrap"}, 32'(ow), 32'(lvl_w[c]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();

    // Reset held with random input activity
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      knoba = N'($urandom);
      knobb = N'($urandom);
    end
    settle(1);
    check("rst_led_sat",  32'(led_s), 32'd0);
    check("rst_led_wrap", 32'(led_w), 32'd0);
    check("rst_val_sat",  32'(val_s), 32'd0);
    check("rst_val_wrap", 32'(val_w), 32'd0);
    check("rst_err_sat",  32'(err_s), 32'd0);
    check("rst_err_wrap", 32'(err_w), 32'd0);
    @(negedge clk);
    knoba = '0;
    knobb = '0;
    reset = 1'b1;
    sb_q.push_back(snap());
    settle(20);
    compare("idle");

    // Exact latency of the first forward step on channel 0
    drive(0, 2'b10);
    settle(6);
    check("lat6_val0", 32'(val_s[3:0]), 32'd0);
    settle(1);
    compare("lat7");

    for (int i = 0; i < 3; i++) fwd(0, "fwd_cycle");
    pdm_check("pdm4", 0);

    for (int i = 0; i < 11; i++) fwd(0, "fwd_to15");
    pdm_check("pdm15", 0);

    for (int i = 0; i < 5; i++) fwd(0, "fwd_over");
    rev(0, "rev_from_top");

    rev(1, "rev_from_0");
    fwd(1, "fwd_from_15");
    pdm_check("pdm0", 2);

    // Debounce: 3-cycle glitch is filtered, 4-cycle pulse yields a step and a return
    @(negedge clk);
    knoba[1] = ~pair[1][1];
    repeat (3) @(negedge clk);
    knoba[1] = pair[1][1];
    sb_q.push_back(snap());
    settle(12);
    compare("glitch3");

    @(negedge clk);
    knoba[1] = ~pair[1][1];
    model_apply(1, {~pair[1][1], pair[1][0]});
    sb_q.push_back(snap());
    repeat (4) @(negedge clk);
    knoba[1] = ~pair[1][1];
    model_apply(1, {~pair[1][1], pair[1][0]});
    sb_q.push_back(snap());
    settle(3);
    compare("pulse4_step");
    settle(8);
    compare("pulse4_back");

    // Illegal double-edge on channel 2, then a legal step
    step(2, 2'b11, "illegal");
    fwd(2, "after_illegal");
    fwd(2, "after_illegal2");

    @(negedge clk);
    reset = 1'b0;
    model_reset();
    knoba = '0;
    knobb = '0;
    sb_q.push_back(snap());
    settle(2);
    compare("rst_again");
    check("rst_again_led_sat", 32'(led_s), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
